hash_cmd_initiator: RTL
=======================

Name: hash_cmd_initiator

Overview:
- Initiator-side driver for the hash core's START/REG1..REG4/AG/DONE interface.
- Accepts four 32-bit operand words from a host over a valid/ready write port and registers them onto REG1..REG4.
- Pulses START, waits for DONE (with a timeout), captures the 5-bit AG result and returns it to the host over a valid/ready result port.
- Sits between the host/bus front end and the hash core instance.

Parameters:
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before aborting; legal range 2..65535.
- TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width; derived, not overridden.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RESET_n  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
- WR_VALID  input  1  host operand word valid.
- WR_DATA  input  32  host operand word.
- WR_READY  output  1  block can accept an operand word.
- FLUSH  input  1  discard partially collected operands; honoured in IDLE only.
- START  output  1  single-cycle launch pulse to the hash core.
- REG1, REG2, REG3, REG4  output  32 each  operand words to the hash core.
- DONE  input  1  hash core completion, level or pulse.
- AG  input  5  hash core result, valid while DONE=1.
- RES_VALID  output  1  result available to the host.
- RES_AG  output  5  captured result.
- RES_ERR  output  1  1 = timeout abort; RES_AG is then 0.
- RES_READY  input  1  host accepts the result.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RESET_n=0 at a clock edge):
  - State goes to IDLE and the word counter to 0.
  - START=0, REG1..REG4=0, RES_VALID=0, RES_AG=0, RES_ERR=0, BUSY=0.
  - WR_READY is 0 while RESET_n=0.
  - Reset mid-operation abandons the transaction silently; START is never left high.
- States: IDLE, LAUNCH, WAIT, RESULT (2-bit encoding).
- IDLE:
  - WR_READY=1.
  - A write is accepted when WR_VALID & WR_READY. The word goes to REG[cnt+1] (cnt 0 -> REG1 ... 3 -> REG4), then cnt increments.
  - When the word with cnt=3 is accepted, cnt wraps to 0 and the state moves to LAUNCH.
  - FLUSH=1 in IDLE sets cnt=0 and leaves REG contents unchanged. If FLUSH and a write occur in the same cycle, FLUSH wins and the word is dropped.
- LAUNCH:
  - START=1 for exactly one cycle, WR_READY=0; next state is WAIT.
  - DONE is not sampled in LAUNCH.
- WAIT:
  - START=0. The timeout counter is cleared on entry and increments each cycle.
  - DONE=1: capture AG into RES_AG, RES_ERR=0, go to RESULT.
  - Counter reaches TIMEOUT_CYCLES-1 without DONE: RES_AG=0, RES_ERR=1, go to RESULT.
  - DONE in the same cycle as the timeout: DONE wins.
- RESULT:
  - RES_VALID=1; RES_AG and RES_ERR are held stable until the handshake.
  - RES_VALID & RES_READY: go to IDLE the next cycle; RES_VALID drops and WR_READY rises in that cycle.
  - If RES_READY is already high when RES_VALID rises, the handshake completes in the first RESULT cycle.
- REG1..REG4 hold their values from the LAUNCH cycle until the next write in IDLE. The core sees stable operands throughout.
- FLUSH and WR_VALID outside IDLE are ignored; no word is accepted.
- Latency:
  - 4th word accepted at cycle N -> START=1 at N+1 -> WAIT from N+2.
  - DONE seen at cycle M -> RES_VALID=1 at M+1.
  - Minimum round trip from the 4th word to RES_VALID is 3 cycles.

Decomposition:
- Shared package hash_pkg holds:
  - typedef hash_state_e {IDLE, LAUNCH, WAIT, RESULT};
  - localparam HASH_NWORDS=4, HASH_WORD_W=32, HASH_AG_W=5.
- Sub-module hash_timeout_ctr: clear/enable inputs, terminal-count output, parameterised by TIMEOUT_CYCLES.
- Operand registers and the FSM stay in the top module.

Test Plan:
- Basic transaction:
  - Write 0x11111111, 0x22222222, 0x33333333, 0x44444444 back to back.
  - REG1..REG4 carry those values; START is high exactly one cycle after the 4th accept.
  - Core model asserts DONE with AG=5'h1A three cycles later -> RES_VALID with RES_AG=0x1A, RES_ERR=0.
- Timeout:
  - TIMEOUT_CYCLES=8; core never asserts DONE.
  - RES_VALID rises 8 cycles after entering WAIT, with RES_ERR=1 and RES_AG=0.
  - The next transaction works normally.
- Flush:
  - Write 2 words, pulse FLUSH with WR_VALID=1 in the same cycle, then write 4 words 0xA..0xD.
  - REG1..REG4 = 0xA, 0xB, 0xC, 0xD; exactly one START pulse.
- Backpressure:
  - Hold RES_READY=0 for 20 cycles in RESULT.
  - RES_VALID and RES_AG stay stable and WR_READY=0 throughout; on RES_READY=1, IDLE follows the next cycle.
- Reset mid-WAIT:
  - Drop RESET_n for one cycle during WAIT.
  - All outputs are at reset values the next cycle, no RES_VALID appears, and a late DONE is ignored.
- Timeout/DONE tie:
  - DONE asserted exactly at terminal count.
  - Result is RES_ERR=0 with RES_AG equal to the AG value.

Source files
------------

// File: rtl/hash_pkg.sv
//============================================================================
// Module      : hash_pkg
// Description : Shared types and constants for the hash core command
//               initiator: FSM state encoding, operand count and widths.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package hash_pkg;

    // Initiator FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } hash_state_e;

    localparam int HASH_NWORDS = 4;
    localparam int HASH_WORD_W = 32;
    localparam int HASH_AG_W   = 5;

endpackage : hash_pkg

`default_nettype wire

// File: rtl/hash_timeout_ctr.sv
//============================================================================
// Module      : hash_timeout_ctr
// Description : Cycle counter bounding the wait for hash core completion.
//               Clears to 0, counts up while enabled and saturates at the
//               terminal count TIMEOUT_CYCLES-1.
// Ports       : clk    - clock, rising edge
//               rst_n  - synchronous active-low reset
//               i_clr  - clear counter to 0 (priority over i_en)
//               i_en   - count enable
//               o_tc   - counter equals TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module hash_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int TO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [TO_W-1:0] c_term_cnt = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_cnt_q;
    logic [TO_W-1:0] w_cnt_d;

    assign o_tc = (r_cnt_q == c_term_cnt);

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_en && !o_tc) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule : hash_timeout_ctr

`default_nettype wire

// File: rtl/hash_cmd_initiator.sv
//============================================================================
// Module      : hash_cmd_initiator
// Description : Initiator-side driver for the hash core START/REG1..REG4/
//               AG/DONE interface. Collects four operand words from the
//               host, launches the core, waits for DONE with a timeout and
//               returns the 5-bit AG result over a valid/ready port.
// Ports       : CLK, RESET_n       - clock, synchronous active-low reset
//               WR_VALID/WR_DATA/WR_READY - host operand write port
//               FLUSH              - drop partially collected operands (IDLE)
//               START, REG1..REG4  - launch pulse and operands to the core
//               DONE, AG           - completion and result from the core
//               RES_VALID/RES_AG/RES_ERR/RES_READY - host result port
//               BUSY               - high outside IDLE
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module hash_cmd_initiator
    import hash_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   CLK,
    input  logic                   RESET_n,
    input  logic                   WR_VALID,
    input  logic [HASH_WORD_W-1:0] WR_DATA,
    output logic                   WR_READY,
    input  logic                   FLUSH,
    output logic                   START,
    output logic [HASH_WORD_W-1:0] REG1,
    output logic [HASH_WORD_W-1:0] REG2,
    output logic [HASH_WORD_W-1:0] REG3,
    output logic [HASH_WORD_W-1:0] REG4,
    input  logic                   DONE,
    input  logic [HASH_AG_W-1:0]   AG,
    output logic                   RES_VALID,
    output logic [HASH_AG_W-1:0]   RES_AG,
    output logic                   RES_ERR,
    input  logic                   RES_READY,
    output logic                   BUSY
);

    localparam logic [1:0] c_last_word = 2'(HASH_NWORDS - 1);

    hash_state_e                                r_state_q,     w_state_d;
    logic [1:0]                                 r_cnt_q,       w_cnt_d;
    logic [HASH_NWORDS-1:0][HASH_WORD_W-1:0]    r_reg_q,       w_reg_d;
    logic                                       r_start_q,     w_start_d;
    logic                                       r_res_valid_q, w_res_valid_d;
    logic [HASH_AG_W-1:0]                       r_res_ag_q,    w_res_ag_d;
    logic                                       r_res_err_q,   w_res_err_d;
    logic                                       r_busy_q,      w_busy_d;

    logic w_wr_ready;
    logic w_wr_accept;
    logic w_to_tc;

    // Ready is forced low during reset so no word is taken in that cycle
    assign w_wr_ready  = RESET_n && (r_state_q == IDLE);
    assign w_wr_accept = WR_VALID && w_wr_ready && !FLUSH;

    // Counter is held at 0 outside WAIT, so it restarts on each WAIT entry
    hash_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk   (CLK),
        .rst_n (RESET_n),
        .i_clr (r_state_q != WAIT),
        .i_en  (r_state_q == WAIT),
        .o_tc  (w_to_tc)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_reg_d       = r_reg_q;
        w_start_d     = 1'b0;
        w_res_valid_d = r_res_valid_q;
        w_res_ag_d    = r_res_ag_q;
        w_res_err_d   = r_res_err_q;
        w_busy_d      = r_busy_q;

        case (r_state_q)
            IDLE: begin
                if (FLUSH) begin
                    // Flush beats a concurrent write; operands are kept
                    w_cnt_d = 2'd0;
                end else if (w_wr_accept) begin
                    w_reg_d[r_cnt_q] = WR_DATA;
                    w_cnt_d          = r_cnt_q + 2'd1;
                    if (r_cnt_q == c_last_word) begin
                        w_state_d = LAUNCH;
                        w_start_d = 1'b1;
                        w_busy_d  = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                w_state_d = WAIT;
            end
            WAIT: begin
                // DONE has priority over a coincident timeout
                if (DONE) begin
                    w_res_ag_d    = AG;
                    w_res_err_d   = 1'b0;
                    w_res_valid_d = 1'b1;
                    w_state_d     = RESULT;
                end else if (w_to_tc) begin
                    w_res_ag_d    = '0;
                    w_res_err_d   = 1'b1;
                    w_res_valid_d = 1'b1;
                    w_state_d     = RESULT;
                end
            end
            RESULT: begin
                if (RES_READY) begin
                    w_res_valid_d = 1'b0;
                    w_busy_d      = 1'b0;
                    w_state_d     = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            r_state_q     <= IDLE;
            r_cnt_q       <= 2'd0;
            r_reg_q       <= '0;
            r_start_q     <= 1'b0;
            r_res_valid_q <= 1'b0;
            r_res_ag_q    <= '0;
            r_res_err_q   <= 1'b0;
            r_busy_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_reg_q       <= w_reg_d;
            r_start_q     <= w_start_d;
            r_res_valid_q <= w_res_valid_d;
            r_res_ag_q    <= w_res_ag_d;
            r_res_err_q   <= w_res_err_d;
            r_busy_q      <= w_busy_d;
        end
    end

    assign WR_READY  = w_wr_ready;
    assign START     = r_start_q;
    assign REG1      = r_reg_q[0];
    assign REG2      = r_reg_q[1];
    assign REG3      = r_reg_q[2];
    assign REG4      = r_reg_q[3];
    assign RES_VALID = r_res_valid_q;
    assign RES_AG    = r_res_ag_q;
    assign RES_ERR   = r_res_err_q;
    assign BUSY      = r_busy_q;

endmodule : hash_cmd_initiator

`default_nettype wire
